alu_nibble_sequencer: RTL and testbench
=======================================

# alu_nibble_sequencer

Multi-word ALU controller that runs one shared 4-bit ALU slice (`alu_4_bit_with_flags_correct`, built on the 74381) serially over an N-nibble operand pair. It processes one nibble per clock, LSB first, and chains the ripple carry between nibbles in a register. It also accumulates whole-word Zero/Negative/Overflow/Carry flags. The block sits between a command source with a start/busy/done handshake and the 4-bit ALU slice, which it instantiates once.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices per word; word width W = 4*NIBBLES; minimum 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: command request; sampled only in IDLE.
- `op` in 3: 74381 function code S (000 CLEAR, 001 B−A, 010 A−B, 011 A+B, 100 XOR, 101 OR, 110 AND, 111 PRESET).
- `cin` in 1: carry-in for A+B only.
- `a`, `b` in W: operands, latched on accept.
- `busy` out 1: high while nibbles are being processed.
- `done` out 1: one-cycle pulse when the result is valid.
- `result` out W: word result, held until the next accept.
- `carry` out 1: final carry-out; 0 for non-arithmetic ops.
- `zero` out 1: result == 0.
- `negative` out 1: result[W-1].
- `overflow` out 1: signed overflow from the top nibble; 0 for non-arithmetic ops.

Reset values: all outputs 0, FSM in IDLE, nibble index 0, internal carry 0.

## Operation
- FSM states:
  - IDLE: `start`=1 → latch `a`, `b`, `op`; set idx=0; load carry register with Cn0; clear the zero accumulator to 1; go to RUN.
  - RUN: on each edge, write the slice output F into result[4*idx+3:4*idx]; carry_reg ← slice Co; zero_acc ← zero_acc & slice Zero. If idx==NIBBLES-1, go to DONE; otherwise idx++.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- Cn0 (carry into the first nibble):
  - A+B: `cin`.
  - A−B and B−A: 1, because the 74381 computes A+~B+Cn; `cin` is ignored.
  - Logic, CLEAR and PRESET: 0.
- Slice inputs in RUN are A/B nibble idx of the latched operands, the latched S, and Cn = carry_reg.
- Final flags update on the DONE transition:
  - `carry` = Co of the last nibble, for arithmetic ops only.
  - `overflow` = slice Overflow of the last nibble.
  - `negative` = last-nibble F[3].
  - `zero` = zero_acc & last-nibble Zero.
- `start` in RUN or DONE is ignored: no queueing, no effect on the operation in progress.
- `a`, `b`, `op` and `cin` may change freely after accept; only the latched copies are used.
- `result` and the flags are stable from `done` until the next accept. On accept they are not cleared; they are overwritten nibble by nibble during RUN and are not valid while `busy`=1.
- Reset asserted mid-operation: everything immediately returns to reset values. No `done` is generated for the aborted command.

## Timing
- Accept at edge k (IDLE, `start`=1). `busy` goes high after edge k and falls after edge k+NIBBLES.
- `done` is high for exactly the cycle after edge k+NIBBLES. Latency is NIBBLES+1 edges from accept to `done` falling.
- Earliest next accept: edge k+NIBBLES+2, the first IDLE edge. Throughput is one command per NIBBLES+2 cycles.
- `busy` and `done` are never high together.
- The slice is purely combinational. The carry chain is broken by carry_reg, so the critical path is one slice per cycle.

## Test plan
- A+B with NIBBLES=4, a=0x1234, b=0x0FCD, cin=0 → result 0x2201, carry 0, overflow 0, zero 0, negative 0. `done` asserted exactly 5 edges after accept, counting the accept edge.
- A+B with a=0x7FFF, b=0x0001, cin=0 → 0x8000, overflow 1, negative 1, carry 0. Repeat with a=0xFFFF, b=0x0001 → 0x0000, carry 1, zero 1, overflow 0.
- A−B with a=b=0x0005 → 0x0000, zero 1, carry 1. B−A with a=0x0001, b=0x0000 → 0xFFFF, negative 1, carry 0. Toggling `cin` has no effect on either.
- AND a=0xF0F0, b=0x0FF0 → 0x00F0, carry 0, overflow 0. PRESET → 0xFFFF. CLEAR → 0x0000 with zero 1.
- Pulse `start` with new operands while busy and during the `done` cycle → neither is accepted, and the first result is unchanged. Then `start` in IDLE → accepted normally.
- Deassert `rst_n` after 2 nibbles → all outputs 0 immediately and no `done`. Release, then issue a new command → correct result with normal latency.

Source files
------------

// File: rtl/alu_nibble_sequencer.sv
// ---------------------------------------------------------------------------
// alu_nibble_sequencer
//
// Multi-word ALU controller. One shared 4-bit ALU slice with 74381 function
// codes is run serially over an N-nibble operand pair. The sequencer handles
// one nibble per clock, least significant nibble first. The ripple carry
// between nibbles is held in a register, so the critical path is a single
// slice per cycle. Whole-word Zero/Negative/Overflow/Carry flags are
// accumulated as the nibbles go through.
//
// Ports (top):
//   clk       in  1   rising-edge clock
//   rst_n     in  1   asynchronous active-low reset
//   start     in  1   command request, sampled only in IDLE
//   op        in  3   74381 function code S
//                       000 CLEAR, 001 B-A, 010 A-B, 011 A+B,
//                       100 XOR,   101 OR,  110 AND, 111 PRESET
//   cin       in  1   carry-in, used by A+B only
//   a, b      in  W   operands (W = 4*NIBBLES), latched on accept
//   busy      out 1   high while nibbles are being processed
//   done      out 1   one-cycle pulse when the result is valid
//   result    out W   word result, held until the next accept
//   carry     out 1   final carry-out (0 for non-arithmetic ops)
//   zero      out 1   result == 0
//   negative  out 1   result[W-1]
//   overflow  out 1   signed overflow (0 for non-arithmetic ops)
//
// Ports (slice alu_4_bit_with_flags_correct):
//   a, b in 4, s in 3, cn in 1 -> f out 4, co, zero, overflow out 1
// ---------------------------------------------------------------------------

// Purely combinational 4-bit ALU slice with 74381 function codes.
// The subtract forms follow the 74381: X + ~Y + Cn. This means a borrow-free
// subtract needs Cn=1, and Co=1 means "no borrow".
module alu_4_bit_with_flags_correct (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] s,
    input  logic       cn,
    output logic [3:0] f,
    output logic       co,
    output logic       zero,
    output logic       overflow
);
    logic [3:0] add_x;
    logic [3:0] add_y;
    logic [4:0] sum;
    logic       arith;

    always_comb begin
        add_x = 4'h0;
        add_y = 4'h0;
        arith = 1'b0;
        case (s)
            3'b001: begin add_x = b; add_y = ~a; arith = 1'b1; end
            3'b010: begin add_x = a; add_y = ~b; arith = 1'b1; end
            3'b011: begin add_x = a; add_y = b;  arith = 1'b1; end
            default: begin add_x = 4'h0; add_y = 4'h0; arith = 1'b0; end
        endcase
    end

    assign sum = {1'b0, add_x} + {1'b0, add_y} + {4'b0000, cn};

    always_comb begin
        f = 4'h0;
        case (s)
            3'b000:  f = 4'h0;
            3'b001,
            3'b010,
            3'b011:  f = sum[3:0];
            3'b100:  f = a ^ b;
            3'b101:  f = a | b;
            3'b110:  f = a & b;
            default: f = 4'hF;
        endcase
    end

    assign co       = arith & sum[4];
    // Signed overflow means both addends have the same sign and the sum has the other sign.
    assign overflow = arith & (add_x[3] == add_y[3]) & (sum[3] != add_x[3]);
    assign zero     = (f == 4'h0);
endmodule

module alu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [2:0]             op,
    input  logic                   cin,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carry,
    output logic                   zero,
    output logic                   negative,
    output logic                   overflow
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [2:0]       op_reg;
    logic             carry_reg;      // inter-nibble ripple carry
    logic             zero_acc_reg;   // AND of the slice Zero flags seen so far
    logic [W-1:0]     result_reg;
    logic             carry_out_reg;
    logic             zero_reg;
    logic             negative_reg;
    logic             overflow_reg;
    logic             busy_reg;
    logic             done_reg;

    // Slice interface
    logic [3:0] slice_a;
    logic [3:0] slice_b;
    logic [3:0] slice_f;
    logic       slice_co;
    logic       slice_zero;
    logic       slice_overflow;
    logic       cn0;

    // Pick nibble idx of the latched operands. Each nibble has its own
    // small compare; an AND-OR of the matches gives a flat mux.
    logic [NIBBLES-1:0][3:0] a_sel;
    logic [NIBBLES-1:0][3:0] b_sel;

    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib_sel
        assign a_sel[gi] = (idx_reg == IDX_W'(gi)) ? a_reg[4*gi +: 4] : 4'h0;
        assign b_sel[gi] = (idx_reg == IDX_W'(gi)) ? b_reg[4*gi +: 4] : 4'h0;
    end

    always_comb begin
        slice_a = 4'h0;
        slice_b = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            slice_a = slice_a | a_sel[i];
            slice_b = slice_b | b_sel[i];
        end
    end

    // Carry into nibble 0. The subtract forms need Cn=1 because the 74381
    // subtracts as X + ~Y + Cn. For these forms, cin is ignored.
    always_comb begin
        cn0 = 1'b0;
        case (op)
            3'b011:        cn0 = cin;
            3'b001, 3'b010: cn0 = 1'b1;
            default:       cn0 = 1'b0;
        endcase
    end

    alu_4_bit_with_flags_correct u_slice (
        .a        (slice_a),
        .b        (slice_b),
        .s        (op_reg),
        .cn       (carry_reg),
        .f        (slice_f),
        .co       (slice_co),
        .zero     (slice_zero),
        .overflow (slice_overflow)
    );

    // Control FSM with registered outputs. The result is written nibble by
    // nibble while busy. The word flags update only on the RUN->DONE edge,
    // so they stay stable from done until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= 3'b000;
            carry_reg     <= 1'b0;
            zero_acc_reg  <= 1'b0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            zero_reg      <= 1'b0;
            negative_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_reg        <= a;
                        b_reg        <= b;
                        op_reg       <= op;
                        idx_reg      <= '0;
                        carry_reg    <= cn0;
                        zero_acc_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    result_reg[4*idx_reg +: 4] <= slice_f;
                    carry_reg    <= slice_co;
                    zero_acc_reg <= zero_acc_reg & slice_zero;
                    if (idx_reg == LAST_IDX) begin
                        carry_out_reg <= slice_co;
                        overflow_reg  <= slice_overflow;
                        negative_reg  <= slice_f[3];
                        zero_reg      <= zero_acc_reg & slice_zero;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    // Any start seen here is dropped on purpose: there is no queueing.
                    done_reg  <= 1'b0;
                    idx_reg   <= '0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign result   = result_reg;
    assign carry    = carry_out_reg;
    assign zero     = zero_reg;
    assign negative = negative_reg;
    assign overflow = overflow_reg;
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_nibble_sequencer
//
// Self-checking bench for alu_nibble_sequencer with NIBBLES=4.
// The expected word results come from whole-word integer arithmetic:
// unsigned and signed sums and differences, plus bitwise logic.
// ---------------------------------------------------------------------------
module tb_alu_nibble_sequencer;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         negative;
    logic         overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         n;
        logic         v;
    } res_t;

    typedef struct {
        logic [2:0]   o;
        logic [W-1:0] xa;
        logic [W-1:0] xb;
        logic         ci;
        res_t         e;
    } vec_t;

    alu_nibble_sequencer #(.NIBBLES(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .cin      (cin),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .zero     (zero),
        .negative (negative),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference model built from whole-word arithmetic.
    function automatic res_t model(input logic [2:0] o, input logic [W-1:0] xa,
                                   input logic [W-1:0] xb, input logic ci);
        res_t m;
        int   ua, ub, sa, sb, ures, sres;
        logic signed [W-1:0] xa_s, xb_s;
        m    = '0;
        xa_s = xa;
        xb_s = xb;
        ua   = int'(xa);
        ub   = int'(xb);
        sa   = int'(xa_s);
        sb   = int'(xb_s);
        ures = 0;
        sres = 0;
        case (o)
            3'd0: m.r = '0;
            3'd1: begin ures = ub - ua; sres = sb - sa;
                        m.r = W'(ures); m.c = (ub >= ua); end
            3'd2: begin ures = ua - ub; sres = sa - sb;
                        m.r = W'(ures); m.c = (ua >= ub); end
            3'd3: begin ures = ua + ub + int'(ci); sres = sa + sb + int'(ci);
                        m.r = W'(ures); m.c = (ures >= (1 << W)); end
            3'd4: m.r = xa ^ xb;
            3'd5: m.r = xa | xb;
            3'd6: m.r = xa & xb;
            default: m.r = '1;
        endcase
        if (o == 3'd1 || o == 3'd2 || o == 3'd3)
            m.v = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
        m.z = (m.r == '0);
        m.n = m.r[W-1];
        return m;
    endfunction

    // Issue one command from IDLE, starting #1 after a rising edge.
    // After the accept edge, the inputs are scrambled to prove that only the latched copies are used.
    // On return, the DUT is back in IDLE and time is #1 after an edge.
    task automatic run_cmd(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                           input logic ci, output res_t got, output int lat, output bit hs_bad);
        op = o; a = xa; b = xb; cin = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); op = 3'($urandom); cin = 1'($urandom);
        lat = 0;
        hs_bad = 1'b0;
        while (done !== 1'b1 && lat < 4 * N + 8) begin
            if (busy !== 1'b1) hs_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (done !== 1'b1) lat = 99;
        if (busy !== 1'b0) hs_bad = 1'b1;
        got = {result, carry, zero, negative, overflow};
        @(posedge clk); #1;
        if (done !== 1'b0 || busy !== 1'b0) hs_bad = 1'b1;
        $display("cmd op=%0d a=%h b=%h cin=%0d -> result=%h c=%0d z=%0d n=%0d v=%0d lat=%0d",
                 o, xa, xb, ci, got.r, got.c, got.z, got.n, got.v, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 3'd0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, result, carry, zero, negative, overflow} !== '0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h flags=%b%b%b%b required all 0",
                     busy, done, result, carry, zero, negative, overflow);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        vec_t  v[10];
        res_t  got;
        int    lat;
        bit    hs_bad;
        //          op    a         b         cin   {result,   c, z, n, v}
        v[0] = '{3'd3, 16'h1234, 16'h0FCD, 1'b0, {16'h2201, 1'b0, 1'b0, 1'b0, 1'b0}};
        v[1] = '{3'd3, 16'h7FFF, 16'h0001, 1'b0, {16'h8000, 1'b0, 1'b0, 1'b1, 1'b1}};
        v[2] = '{3'd3, 16'hFFFF, 16'h0001, 1'b0, {16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}};
        v[3] = '{3'd2, 16'h0005, 16'h0005, 1'b0, {16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}};
        v[4] = '{3'd2, 16'h0005, 16'h0005, 1'b1, {16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}};
        v[5] = '{3'd1, 16'h0001, 16'h0000, 1'b0, {16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0}};
        v[6] = '{3'd1, 16'h0001, 16'h0000, 1'b1, {16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0}};
        v[7] = '{3'd6, 16'hF0F0, 16'h0FF0, 1'b1, {16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0}};
        v[8] = '{3'd7, 16'h1234, 16'h5678, 1'b1, {16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0}};
        v[9] = '{3'd0, 16'h1234, 16'h5678, 1'b1, {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}};
        for (int i = 0; i < 10; i++) begin
            run_cmd(v[i].o, v[i].xa, v[i].xb, v[i].ci, got, lat, hs_bad);
            checks++;
            if (got !== v[i].e) begin
                failures++;
                $display("FAIL directed_%0d: got %h/%b%b%b%b required %h/%b%b%b%b", i,
                         got.r, got.c, got.z, got.n, got.v,
                         v[i].e.r, v[i].e.c, v[i].e.z, v[i].e.n, v[i].e.v);
            end
            checks++;
            if (lat != N) begin
                failures++;
                $display("FAIL directed_latency_%0d: got %0d edges after accept, required %0d", i, lat, N);
            end
            checks++;
            if (hs_bad) begin
                failures++;
                $display("FAIL directed_handshake_%0d: busy/done sequence wrong", i);
            end
        end
    endtask

    task automatic test_random();
        res_t         got, exp;
        int           lat;
        bit           hs_bad;
        logic [2:0]   o;
        logic [W-1:0] xa, xb;
        logic         ci;
        for (int i = 0; i < 40; i++) begin
            o  = 3'($urandom);
            xa = W'($urandom);
            xb = W'($urandom);
            ci = 1'($urandom);
            if (i % 8 == 0) xb = xa;  // regularly hit the zero / equal-operand cases
            exp = model(o, xa, xb, ci);
            run_cmd(o, xa, xb, ci, got, lat, hs_bad);
            checks++;
            if (got !== exp || lat != N || hs_bad) begin
                failures++;
                $display("FAIL random_%0d: op=%0d a=%h b=%h cin=%0d got %h/%b%b%b%b lat=%0d hs=%0d required %h/%b%b%b%b lat=%0d",
                         i, o, xa, xb, ci, got.r, got.c, got.z, got.n, got.v, lat, hs_bad,
                         exp.r, exp.c, exp.z, exp.n, exp.v, N);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t got, exp;
        int   lat;
        bit   hs_bad;
        // Each command is issued on the first IDLE edge after the previous done.
        for (int i = 0; i < 6; i++) begin
            exp = model(3'd3, W'(16'h1111 * i), 16'hF00F, 1'(i));
            run_cmd(3'd3, W'(16'h1111 * i), 16'hF00F, 1'(i), got, lat, hs_bad);
            checks++;
            if (got !== exp || lat != N || hs_bad) begin
                failures++;
                $display("FAIL back_to_back_%0d: got %h/%b%b%b%b lat=%0d required %h/%b%b%b%b lat=%0d",
                         i, got.r, got.c, got.z, got.n, got.v, lat,
                         exp.r, exp.c, exp.z, exp.n, exp.v, N);
            end
        end
    endtask

    task automatic test_start_ignored();
        res_t got, exp;
        int   lat;
        bit   hs_bad;
        op = 3'd3; a = 16'h1234; b = 16'h0FCD; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        // Keep requesting a different command throughout RUN and the done cycle.
        a = 16'hFFFF; b = 16'hFFFF; op = 3'd7; cin = 1'b1;
        lat = 0;
        while (done !== 1'b1 && lat < 4 * N + 8) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != N || result !== 16'h2201) begin
            failures++;
            $display("FAIL start_busy_ignored: got result=%h lat=%0d required 2201 lat=%0d", result, lat, N);
        end
        @(posedge clk); #1;   // edge taken in DONE with start still high
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h2201) begin
            failures++;
            $display("FAIL start_done_ignored: got busy=%b done=%b result=%h required 0 0 2201",
                     busy, done, result);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || result !== 16'h2201) begin
            failures++;
            $display("FAIL start_idle_quiet: got busy=%b result=%h required 0 2201", busy, result);
        end
        exp = model(3'd5, 16'hA050, 16'h0A05, 1'b0);
        run_cmd(3'd5, 16'hA050, 16'h0A05, 1'b0, got, lat, hs_bad);
        checks++;
        if (got !== exp || lat != N || hs_bad) begin
            failures++;
            $display("FAIL start_after_ignore: got %h lat=%0d required %h lat=%0d", got.r, lat, exp.r, N);
        end
    endtask

    task automatic test_reset_midop();
        res_t got, exp;
        int   lat;
        bit   hs_bad;
        bit   saw_done;
        op = 3'd3; a = 16'h7FFF; b = 16'h7FFF; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);   // two nibbles processed
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, carry, zero, negative, overflow} !== '0) begin
            failures++;
            $display("FAIL reset_midop: got busy=%b done=%b result=%h flags=%b%b%b%b required all 0",
                     busy, done, result, carry, zero, negative, overflow);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done !== 1'b0) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (N + 2) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL reset_no_done: got done/busy activity after abort, required none");
        end
        exp = model(3'd2, 16'h8000, 16'h0001, 1'b0);
        run_cmd(3'd2, 16'h8000, 16'h0001, 1'b0, got, lat, hs_bad);
        checks++;
        if (got !== exp || lat != N || hs_bad) begin
            failures++;
            $display("FAIL reset_recover: got %h/%b%b%b%b lat=%0d required %h/%b%b%b%b lat=%0d",
                     got.r, got.c, got.z, got.n, got.v, lat,
                     exp.r, exp.c, exp.z, exp.n, exp.v, N);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_start_ignored();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end
endmodule
